// File: rtl/spi_sck_if.sv
// spi_sck_if: control and strobe bundle between the transaction controller and the SCK generator.
interface spi_sck_if #(parameter int DIV_W = 10, parameter int BITS_W = 6);
  logic              i_start;
  logic              i_abort;
  logic [DIV_W-1:0]  i_half_div;
  logic [BITS_W-1:0] i_nbits;
  logic              i_cpol;
  logic              i_cpha;
  logic              o_sck;
  logic              o_sample;
  logic              o_shift;
  logic              o_busy;
  logic              o_done;
  logic [BITS_W-1:0] o_bit_cnt;
  modport master(output i_start, i_abort, i_half_div, i_nbits, i_cpol, i_cpha,
                 input o_sck, o_sample, o_shift, o_busy, o_done, o_bit_cnt);
  modport slave(input i_start, i_abort, i_half_div, i_nbits, i_cpol, i_cpha,
                output o_sck, o_sample, o_shift, o_busy, o_done, o_bit_cnt);
endinterface

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: registered SPI SCK generator with runtime divisor, CPOL/CPHA and burst counting.
module spi_sck_gen #(
  parameter int   DIV_W   = 10,
  parameter int   BITS_W  = 6,
  parameter logic SCK_RST = 1'b0
) (
  input  logic        i_clk_27_MHz,
  input  logic        i_rst,
  spi_sck_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;
  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, h_q, h_d;
  logic [BITS_W:0]   edge_q, edge_d;
  logic [BITS_W-1:0] n_q, n_d, bit_cnt_q, bit_cnt_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic              sck_q, sck_d, sample_q, sample_d, shift_q, shift_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              lead;
  always_ff @(posedge i_clk_27_MHz or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      h_q       <= '0;
      edge_q    <= '0;
      n_q       <= '0;
      bit_cnt_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sck_q     <= SCK_RST;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_q       <= h_d;
      edge_q    <= edge_d;
      n_q       <= n_d;
      bit_cnt_q <= bit_cnt_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sck_q     <= sck_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_d       = h_q;
    edge_d    = edge_q;
    n_d       = n_q;
    bit_cnt_d = bit_cnt_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sck_d     = sck_q;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lead      = 1'b0;
    case (state_q)
      IDLE: begin
        sck_d = bus.i_cpol;
        if (bus.i_start && bus.i_nbits != '0) begin
          h_d       = bus.i_half_div;
          n_d       = bus.i_nbits;
          cpol_d    = bus.i_cpol;
          cpha_d    = bus.i_cpha;
          cnt_d     = '0;
          edge_d    = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (bus.i_abort) begin
          sck_d   = cpol_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == h_q) begin
          cnt_d    = '0;
          edge_d   = edge_q + 1'b1;
          sck_d    = ~sck_q;
          lead     = edge_d[0];
          sample_d = cpha_q ? ~lead : lead;
          // with cpha=0 the final trailing edge has no next bit to present
          shift_d  = cpha_q ? lead : (~lead && edge_d != {n_q, 1'b0});
          if (sample_d && bit_cnt_q != n_q) bit_cnt_d = bit_cnt_q + 1'b1;
          if (edge_d == {n_q, 1'b0}) state_d = TAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TAIL: begin
        if (bus.i_abort) begin
          sck_d   = cpol_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == h_q) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.o_sck     = sck_q;
  assign bus.o_sample  = sample_q;
  assign bus.o_shift   = shift_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_bit_cnt = bit_cnt_q;
endmodule

// File: tb/tb_spi_sck_gen.sv
// tb_spi_sck_gen: random and directed bursts checked cycle by cycle against an arithmetic timing model.
module tb_spi_sck_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_pass = 0;
  int   busy_n, tog_n, smp_n, shf_n, done_n;
  logic prev_sck;
  logic m_act;
  int   t, mh, mn, e_bc;
  logic mcpol, mcpha, e_sck, e_smp, e_shf, e_busy, e_done;
  logic [10:0] obs, expv;
  spi_sck_if #(.DIV_W(10), .BITS_W(6)) bus();
  spi_sck_gen #(.DIV_W(10), .BITS_W(6), .SCK_RST(1'b0)) dut (
    .i_clk_27_MHz(clk),
    .i_rst(rst),
    .bus(bus)
  );
  always #18 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  task model_step();
    int p, e, k;
    e_smp  = 1'b0;
    e_shf  = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_act = 1'b0; e_sck = 1'b0; e_busy = 1'b0; e_bc = 0;
    end else if (!m_act) begin
      e_sck  = bus.i_cpol;
      e_busy = 1'b0;
      if (bus.i_start && bus.i_nbits != 0) begin
        m_act = 1'b1; t = 0; e_bc = 0; e_busy = 1'b1;
        mh = int'(bus.i_half_div); mn = int'(bus.i_nbits);
        mcpol = bus.i_cpol; mcpha = bus.i_cpha;
      end
    end else if (bus.i_abort) begin
      m_act = 1'b0; e_sck = mcpol; e_busy = 1'b0;
    end else begin
      t++;
      p = mh + 1;
      e = t / p;
      k = (e < 2 * mn) ? e : 2 * mn;
      e_sck = mcpol ^ k[0];
      if (t % p == 0 && e >= 1 && e <= 2 * mn) begin
        e_smp = mcpha ? (e % 2 == 0) : (e % 2 == 1);
        e_shf = mcpha ? (e % 2 == 1) : (e % 2 == 0 && e != 2 * mn);
      end
      e_bc   = mcpha ? k / 2 : (k + 1) / 2;
      e_done = (t == (2 * mn + 1) * p);
      e_busy = !e_done;
      if (e_done) m_act = 1'b0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    obs  = {bus.o_sck, bus.o_sample, bus.o_shift, bus.o_busy, bus.o_done, bus.o_bit_cnt};
    expv = {e_sck, e_smp, e_shf, e_busy, e_done, 6'(e_bc)};
    chk("cycle", 32'(obs), 32'(expv));
    busy_n += int'(bus.o_busy);
    smp_n  += int'(bus.o_sample);
    shf_n  += int'(bus.o_shift);
    done_n += int'(bus.o_done);
    tog_n  += int'(bus.o_sck != prev_sck);
    prev_sck = bus.o_sck;
  endtask
  task automatic clr();
    busy_n = 0; tog_n = 0; smp_n = 0; shf_n = 0; done_n = 0;
    prev_sck = bus.o_sck;
  endtask
  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask
  task automatic setup(input int h, input int n, input logic pol, input logic pha);
    bus.i_half_div = 10'(h);
    bus.i_nbits    = 6'(n);
    bus.i_cpol     = pol;
    bus.i_cpha     = pha;
    repeat (2) tick();
    clr();
  endtask
  initial begin
    bus.i_start = 1'b0; bus.i_abort = 1'b0;
    bus.i_half_div = '0; bus.i_nbits = '0; bus.i_cpol = 1'b0; bus.i_cpha = 1'b0;
    m_act = 1'b0; t = 0; mh = 0; mn = 0; e_bc = 0; mcpol = 1'b0; mcpha = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    clr();
    setup(0, 8, 1'b0, 1'b0);
    pulse_start();
    repeat (20) tick();
    chk("a_busy", busy_n, 17);
    chk("a_tog", tog_n, 16);
    chk("a_smp", smp_n, 8);
    chk("a_shf", shf_n, 7);
    chk("a_done", done_n, 1);
    chk("a_bitcnt", 32'(bus.o_bit_cnt), 8);
    setup(134, 1, 1'b1, 1'b1);
    chk("b_idle_sck", 32'(bus.o_sck), 1);
    pulse_start();
    repeat (410) tick();
    chk("b_busy", busy_n, 405);
    chk("b_tog", tog_n, 2);
    chk("b_smp", smp_n, 1);
    chk("b_shf", shf_n, 1);
    chk("b_done", done_n, 1);
    setup(1, 4, 1'b0, 1'b0);
    pulse_start();
    repeat (4) tick();
    bus.i_half_div = 10'd7;
    pulse_start();
    repeat (25) tick();
    chk("c_busy", busy_n, 18);
    chk("c_tog", tog_n, 8);
    chk("c_done", done_n, 1);
    setup(2, 8, 1'b0, 1'b0);
    pulse_start();
    for (int i = 0; i < 200 && tog_n < 3; i++) tick();
    chk("d_reach_e3", tog_n, 3);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("d_bitcnt", 32'(bus.o_bit_cnt), 2);
    chk("d_busy", 32'(bus.o_busy), 0);
    repeat (30) tick();
    chk("d_done", done_n, 0);
    setup(0, 0, 1'b0, 1'b0);
    pulse_start();
    repeat (5) tick();
    chk("e_busy0", busy_n, 0);
    chk("e_strb0", smp_n + shf_n, 0);
    chk("e_done0", done_n, 0);
    bus.i_nbits = 6'd2;
    pulse_start();
    repeat (8) tick();
    chk("e_busy", busy_n, 5);
    chk("e_done", done_n, 1);
    setup(3, 8, 1'b0, 1'b0);
    pulse_start();
    repeat (6) tick();
    #2 rst = 1'b1;
    #1 chk("f_rst_async", 32'({bus.o_sck, bus.o_sample, bus.o_shift, bus.o_busy, bus.o_done, bus.o_bit_cnt}), 0);
    repeat (3) tick();
    rst = 1'b0;
    clr();
    repeat (5) tick();
    chk("f_idle", busy_n, 0);
    for (int i = 0; i < 3000; i++) begin
      bus.i_start    = ($urandom_range(0, 7) == 0);
      bus.i_abort    = ($urandom_range(0, 49) == 0);
      bus.i_half_div = 10'($urandom_range(0, 4));
      bus.i_nbits    = 6'($urandom_range(0, 9));
      bus.i_cpol     = 1'($urandom_range(0, 1));
      bus.i_cpha     = 1'($urandom_range(0, 1));
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
